// File: rtl/sub_seq_ctrl.sv
// sub_seq_ctrl: byte-serial sequencer for W=8*NBYTES unsigned subtraction
// on a shared external 8-bit subtractor (sub_8bit), LSB byte first.
// Optional build macro: SUB_SEQ_SAT_EN clamps a borrowing result to zero.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; operands latched on the accepting edge
// S_RUN  | one byte pair per cycle through sub_8bit, borrow chained
// S_DONE | one-cycle done pulse; result/borrow_out valid and held
module sub_seq_ctrl #(
    parameter int NBYTES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   a_in,
    input  logic [8*NBYTES-1:0]   b_in,
    output logic [7:0]            sub_a,
    output logic [7:0]            sub_b,
    input  logic [7:0]            sub_d,
    input  logic                  sub_bout,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  borrow_out
);

    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDXW-1:0]   r_idx;
    logic              r_bin;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_result;
    logic              r_borrow;

    logic [7:0]        w_ai;
    logic [7:0]        w_bi;
    logic              w_special;
    logic [7:0]        w_byte;
    logic              w_bin_nxt;
    logic              w_last;

    // Current byte pair and the borrow chain step. When bi==FF with a
    // borrow-in, bi+bin wraps to 0 in 8 bits, so the subtractor output is
    // meaningless: the true difference is ai with a borrow out.
    always_comb begin
        w_ai      = r_a[8*r_idx +: 8];
        w_bi      = r_b[8*r_idx +: 8];
        w_special = (w_bi == 8'hFF) && r_bin;
        w_byte    = w_special ? w_ai : sub_d;
        w_bin_nxt = w_special ? 1'b1 : sub_bout;
        w_last    = (r_idx == IDXW'(NBYTES - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        sub_a       = 8'h00;
        sub_b       = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                sub_a = w_ai;
                sub_b = w_bi + {7'b0, r_bin};
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand latch, byte index, borrow chain and result assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_idx    <= '0;
            r_bin    <= 1'b0;
            r_result <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= a_in;
                        r_b   <= b_in;
                        r_idx <= '0;
                        r_bin <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_result[8*r_idx +: 8] <= w_byte;
                    r_bin                  <= w_bin_nxt;
                    if (w_last) begin
                        r_idx    <= '0;
                        r_borrow <= w_bin_nxt;
`ifdef SUB_SEQ_SAT_EN
                        if (w_bin_nxt) begin
                            r_result <= '0;
                        end
`endif
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result     = r_result;
    assign borrow_out = r_borrow;

endmodule
